// File: rtl/uart_tx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_pkg
//   Shared definitions for the buffered UART transmitter: FSM state encoding,
//   frame geometry and default parameter values.
// ----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    // 3-bit state encoding for the transmit FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 16;
    localparam int DEFAULT_FIFO_AW = 4;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_sync_fifo
//   Single-clock show-ahead FIFO. rdata always presents the head entry, so a
//   pop consumes the value visible in the same cycle.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (clears pointers)
//   push   in   write request; ignored when full
//   wdata  in   write data
//   pop    in   read request; ignored when empty
//   rdata  out  head entry (valid when !empty)
//   full   out  FIFO holds 2**AW entries
//   empty  out  FIFO holds no entries
//   level  out  number of stored entries
// ----------------------------------------------------------------------------
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int AW    = DEFAULT_FIFO_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra bit so full and empty are distinguishable;
    // the difference wraps naturally and is the fill level directly.
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = level[AW];
        empty    = (level == '0);
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        rdata    = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule : uart_tx_fifo_sync_fifo

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Byte writes land in a FIFO and are serialised
//   LSB first as 8N1 frames (optional parity bit before stop). Back-to-back
//   queued bytes are sent with no idle gap between stop and next start.
//
// Ports
//   clk       in   UART clock (CLK_DIV cycles per serial bit)
//   rst       in   asynchronous active-high reset; aborts frame, drops queue
//   wrsig     in   write strobe, one byte per high cycle
//   datain    in   byte written when wrsig=1
//   tx        out  serial line, idle high, registered
//   idle      out  FSM idle and FIFO empty
//   full      out  FIFO full
//   overflow  out  1-cycle pulse: a write was dropped because FIFO was full
//   level     out  bytes waiting in FIFO (excludes the byte on the wire)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (low) for CLK_DIV cycles
// ST_DATA   | data bits LSB first, CLK_DIV cycles each
// ST_PARITY | parity bit (only when PARITY_EN)
// ST_STOP   | stop bit (high); chains straight into next START if queued
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_AW    = DEFAULT_FIFO_AW,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrsig,
    input  logic [7:0]           datain,
    output logic                 tx,
    output logic                 idle,
    output logic                 full,
    output logic                 overflow,
    output logic [FIFO_AW:0]     level
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic              PAR_INIT  = (PARITY_ODD != 0);

    // FIFO interface
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_level;
    logic                 fifo_pop;

    // Transmit datapath and FSM state
    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q, overflow_d;
    logic                 baud_last;
    logic                 load;

    uart_tx_fifo_sync_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wrsig),
        .wdata (datain),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        load       = 1'b0;
        baud_last  = (baud_cnt_q == BAUD_LAST);
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + BAUD_W'(1);

        // Registered full: a pop in the same cycle does not admit a write.
        overflow_d = wrsig & fifo_full;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                load       = ~fifo_empty;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    // Parity folds in each bit as it leaves the shifter.
                    par_d     = par_q ^ shift_q[0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q ^ shift_q[0];
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
            end
        endcase

        // Shared frame launch from IDLE or from the end of STOP.
        if (load) begin
            state_d    = ST_START;
            shift_d    = fifo_rdata;
            par_d      = PAR_INIT;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = 1'b0;
        end
        fifo_pop = load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign idle     = (state_q == ST_IDLE) & fifo_empty;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign level    = fifo_level;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr0, wr1, wr2;
    logic [7:0] d0, d1, d2;
    logic       tx0, tx1, tx2;
    logic       idle0, idle1, idle2;
    logic       full0, full1, full2;
    logic       ovf0, ovf1, ovf2;
    logic [4:0] lvl0, lvl1, lvl2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_DIV(16), .FIFO_AW(4), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .wrsig(wr0), .datain(d0), .tx(tx0),
        .idle(idle0), .full(full0), .overflow(ovf0), .level(lvl0));

    uart_tx_fifo #(.CLK_DIV(16), .FIFO_AW(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .wrsig(wr1), .datain(d1), .tx(tx1),
        .idle(idle1), .full(full1), .overflow(ovf1), .level(lvl1));

    uart_tx_fifo #(.CLK_DIV(16), .FIFO_AW(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .wrsig(wr2), .datain(d2), .tx(tx2),
        .idle(idle2), .full(full2), .overflow(ovf2), .level(lvl2));

    // Independent line receiver for dut0: samples mid-bit, 10-bit frames
    // stored as {stop, d7..d0, start}.
    logic [9:0] mon_bits_q [$];
    int         mon_start_q [$];
    logic       mon_busy = 1'b0;
    int         mon_cnt  = 0;
    int         mon_start = 0;
    logic [9:0] mon_shift = '0;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
            mon_cnt  = 0;
        end else if (!mon_busy) begin
            if (tx0 === 1'b0) begin
                mon_busy  = 1'b1;
                mon_cnt   = 0;
                mon_start = cyc;
                mon_shift = '0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 16 == 8) begin
                mon_shift = {tx0, mon_shift[9:1]};
                if (mon_cnt == 152) begin
                    mon_bits_q.push_back(mon_shift);
                    mon_start_q.push_back(mon_start);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    int ovf_cnt    = 0;
    int lvl_hi_cnt = 0;
    always @(negedge clk) begin
        if (ovf0 === 1'b1) ovf_cnt++;
        if (lvl0 > 5'd1)   lvl_hi_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int limit);
        int t;
        t = 0;
        while (mon_bits_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("frame_count", mon_bits_q.size(), n);
    endtask

    string      msg;
    logic [9:0] fb;
    logic [10:0] p1, p2;
    int         st, prev_st, o0, h0, lows;

    initial begin
        msg = "Hello ALINX AX516 \n\r";
        rst = 1'b1;
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx0",   tx0, 1);
        chk("rst_idle0", idle0, 1);
        chk("rst_full0", full0, 0);
        chk("rst_ovf0",  ovf0, 0);
        chk("rst_lvl0",  lvl0, 0);
        chk("rst_tx1",   tx1, 1);
        chk("rst_tx2",   tx2, 1);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single byte 0x48, latency and frame shape
        @(negedge clk); wr0 = 1'b1; d0 = 8'h48;
        @(negedge clk); wr0 = 1'b0;
        chk("t1_lvl_n1",  lvl0, 1);
        chk("t1_idle_n1", idle0, 0);
        chk("t1_tx_n1",   tx0, 1);
        @(negedge clk);
        chk("t1_tx_n2",  tx0, 0);
        chk("t1_lvl_n2", lvl0, 0);
        repeat (159) @(negedge clk);
        chk("t1_idle_n161", idle0, 0);
        @(negedge clk);
        chk("t1_idle_n162", idle0, 1);
        chk("t1_tx_n162",   tx0, 1);
        wait_frames(1, 10);
        if (mon_bits_q.size() > 0) begin
            fb = mon_bits_q.pop_front();
            void'(mon_start_q.pop_front());
            chk("t1_frame", fb, {1'b1, 8'h48, 1'b0});
        end

        // Test 2 + 6: burst of 20, then push while full with a same-cycle pop
        o0 = ovf_cnt;
        for (int k = 0; k <= 162; k++) begin
            @(negedge clk);
            if (k == 17) begin
                chk("t2_lvl16",  lvl0, 16);
                chk("t2_full",   full0, 1);
                chk("t2_ovf_17", ovf0, 0);
            end
            if (k >= 18 && k <= 20) chk("t2_ovf_pulse", ovf0, 1);
            if (k == 21) chk("t2_ovf_end", ovf0, 0);
            if (k == 161) begin
                chk("t6_full_before", full0, 1);
                chk("t6_lvl_before",  lvl0, 16);
            end
            if (k == 162) begin
                chk("t6_ovf",  ovf0, 1);
                chk("t6_lvl",  lvl0, 15);
                chk("t6_full", full0, 0);
            end
            wr0 = (k < 20) || (k == 161);
            d0  = (k < 20) ? 8'(k) : 8'hEE;
        end
        wait_frames(17, 4000);
        prev_st = 0;
        for (int i = 0; i < 17; i++) begin
            if (mon_bits_q.size() > 0) begin
                fb = mon_bits_q.pop_front();
                st = mon_start_q.pop_front();
                chk("t2_byte", fb, {1'b1, 8'(i), 1'b0});
                if (i > 0) chk("t2_gap", st - prev_st, 160);
                prev_st = st;
            end
        end
        chk("t2_ovf_total", ovf_cnt - o0, 4);
        repeat (10) @(negedge clk);
        chk("t2_idle_end", idle0, 1);
        chk("t2_lvl_end",  lvl0, 0);

        // Test 3: paced string, one byte every 255 clocks
        o0 = ovf_cnt;
        h0 = lvl_hi_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); wr0 = 1'b1; d0 = msg[i];
            @(negedge clk); wr0 = 1'b0;
            repeat (253) @(negedge clk);
        end
        wait_frames(20, 1000);
        for (int i = 0; i < 20; i++) begin
            if (mon_bits_q.size() > 0) begin
                fb = mon_bits_q.pop_front();
                void'(mon_start_q.pop_front());
                chk("t3_char", fb, {1'b1, msg[i], 1'b0});
            end
        end
        chk("t3_no_ovf",   ovf_cnt - o0, 0);
        chk("t3_level_le1", lvl_hi_cnt - h0, 0);

        // Test 4: parity even (dut1) and odd (dut2), byte 0x07
        p1 = '0; p2 = '0;
        @(negedge clk); wr1 = 1'b1; wr2 = 1'b1; d1 = 8'h07; d2 = 8'h07;
        for (int k = 1; k <= 178; k++) begin
            @(negedge clk);
            if (k == 1) begin wr1 = 1'b0; wr2 = 1'b0; end
            if (k == 2) begin
                chk("t4_start_even", tx1, 0);
                chk("t4_start_odd",  tx2, 0);
            end
            if (k >= 10 && k <= 170 && (k - 10) % 16 == 0) begin
                p1 = {tx1, p1[10:1]};
                p2 = {tx2, p2[10:1]};
            end
            if (k == 177) begin
                chk("t4_busy_even", idle1, 0);
                chk("t4_busy_odd",  idle2, 0);
            end
            if (k == 178) begin
                chk("t4_idle_even", idle1, 1);
                chk("t4_idle_odd",  idle2, 1);
            end
        end
        chk("t4_frame_even", p1, {1'b1, 1'b1, 8'h07, 1'b0});
        chk("t4_frame_odd",  p2, {1'b1, 1'b0, 8'h07, 1'b0});

        // Test 5: reset 70 clocks into a frame with 3 bytes queued
        for (int k = 0; k <= 72; k++) begin
            @(negedge clk);
            if (k == 72) begin
                chk("t5_tx_mid", tx0, 0);
                chk("t5_lvl3",   lvl0, 3);
            end
            wr0 = (k < 4);
            d0  = 8'hA1 + 8'(k);
        end
        #2 rst = 1'b1;
        #1;
        chk("t5_tx_async", tx0, 1);
        chk("t5_lvl0",     lvl0, 0);
        chk("t5_idle",     idle0, 1);
        chk("t5_full",     full0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
        end
        chk("t5_line_high", lows, 0);
        chk("t5_no_frames", mon_bits_q.size(), 0);
        chk("t5_idle_after", idle0, 1);
        @(negedge clk); wr0 = 1'b1; d0 = 8'h5A;
        @(negedge clk); wr0 = 1'b0;
        wait_frames(1, 300);
        if (mon_bits_q.size() > 0) begin
            fb = mon_bits_q.pop_front();
            void'(mon_start_q.pop_front());
            chk("t5_recover", fb, {1'b1, 8'h5A, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo
